// File: rtl/four_bit_adder.sv
// four_bit_adder
//   4-bit ripple-carry adder with carry-in, carry-out and signed overflow.
//   The combinational result comes from four chained full-adder cells.
//   A registered copy of the result is kept for synchronous consumers.
//
// Ports (declaration order is fixed for positional instantiations):
//   sum     out [3:0]  combinational sum, (a + b + c) mod 16
//   c_out   out        combinational carry out of bit 3
//   c       in         carry in to bit 0
//   a, b    in  [3:0]  operands, two's complement (same bits when unsigned)
//   clk     in         rising-edge clock, registered outputs only
//   rst     in         asynchronous active-high reset, registered outputs only
//   ovf     out        combinational signed overflow
//   sum_q   out [3:0]  registered sum
//   c_out_q out        registered carry out
//   ovf_q   out        registered overflow

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module four_bit_adder (
   output logic [3:0] sum,
   output logic       c_out,
   input  logic       c,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       clk,
   input  logic       rst,
   output logic       ovf,
   output logic [3:0] sum_q,
   output logic       c_out_q,
   output logic       ovf_q
);
   // k[i] is the carry into cell i; k[4] leaves the top cell.
   logic [4:0] k;

   assign k[0] = c;

   fa_cell u_fa [3:0] (
      .a  (a),
      .b  (b),
      .ci (k[3:0]),
      .s  (sum),
      .co (k[4:1])
   );

   assign c_out = k[4];
   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf   = k[4] ^ k[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= 4'b0000;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sum_q   <= sum;
         c_out_q <= c_out;
         ovf_q   <= ovf;
      end
   end
endmodule

// File: tb/tb_four_bit_adder.sv
module tb_four_bit_adder;
   logic [3:0] sum, a, b, sum_q;
   logic       c_out, c, clk, rst, ovf, c_out_q, ovf_q;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] sum;
      logic       c_out;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [3:0] sum;
      logic       c_out;
      logic       ovf;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   four_bit_adder dut (
      .sum     (sum),
      .c_out   (c_out),
      .c       (c),
      .a       (a),
      .b       (b),
      .clk     (clk),
      .rst     (rst),
      .ovf     (ovf),
      .sum_q   (sum_q),
      .c_out_q (c_out_q),
      .ovf_q   (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_regs(input string nm, input exp_t e);
      chk({nm, " sum_q"},   8'(sum_q),   8'(e.sum));
      chk({nm, " c_out_q"}, 8'(c_out_q), 8'(e.c_out));
      chk({nm, " ovf_q"},   8'(ovf_q),   8'(e.ovf));
   endtask

   initial begin
      exp_t e, zero, last;
      bit   have_last;
      int   ua, sa, ai, bi;

      vecs[0] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[2] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
      vecs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
      vecs[4] = '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1};
      vecs[5] = '{4'b0011, 4'b0100, 1'b1, 4'b1000, 1'b0, 1'b1};
      zero = '{4'b0000, 1'b0, 1'b0};

      // Reset: registers clear without a clock edge, comb path live.
      rst = 1'b0; a = 4'b0011; b = 4'b0100; c = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk_regs("reset", zero);
      chk("reset comb sum", 8'(sum), 8'h08);
      @(posedge clk); #1;
      chk_regs("reset hold", zero);
      @(negedge clk) rst = 1'b0;

      // Exhaustive combinational sweep against an arithmetic model.
      for (int ci = 0; ci < 2; ci++)
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
               a = 4'(i); b = 4'(j); c = 1'(ci);
               #2;
               ua = i + j + ci;
               ai = (i >= 8) ? i - 16 : i;
               bi = (j >= 8) ? j - 16 : j;
               sa = ai + bi + ci;
               chk($sformatf("sweep %0d+%0d+%0d sum", i, j, ci), 8'({c_out, sum}), 8'(ua));
               chk($sformatf("sweep %0d+%0d+%0d ovf", i, j, ci), 8'(ovf),
                   8'((sa > 7 || sa < -8) ? 1 : 0));
            end

      // Directed corner vectors on the combinational path.
      foreach (vecs[i]) begin
         a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
         #2;
         chk($sformatf("vec%0d sum", i),   8'(sum),   8'(vecs[i].sum));
         chk($sformatf("vec%0d c_out", i), 8'(c_out), 8'(vecs[i].c_out));
         chk($sformatf("vec%0d ovf", i),   8'(ovf),   8'(vecs[i].ovf));
      end

      // Registered path through the scoreboard, with hold checks between edges.
      have_last = 1'b0;
      foreach (vecs[i]) begin
         @(negedge clk);
         a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
         sb.push_back('{vecs[i].sum, vecs[i].c_out, vecs[i].ovf});
         #1;
         if (have_last) chk_regs($sformatf("hold%0d", i), last);
         @(posedge clk); #1;
         e = sb.pop_front();
         chk_regs($sformatf("reg%0d", i), e);
         last = e;
         have_last = 1'b1;
      end

      // Mid-operation asynchronous reset.
      @(negedge clk);
      a = 4'b0011; b = 4'b0100; c = 1'b1;
      sb.push_back('{4'b1000, 1'b0, 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk_regs("pre-rst", e);
      #2 rst = 1'b1;
      #1;
      chk_regs("async rst", zero);
      chk("async rst comb sum", 8'(sum), 8'h08);
      chk("async rst comb ovf", 8'(ovf), 8'h01);
      @(posedge clk); #1;
      chk_regs("rst held", zero);
      @(negedge clk) rst = 1'b0;
      sb.push_back('{4'b1000, 1'b0, 1'b1});
      #1;
      chk_regs("post-rst no edge", zero);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk_regs("post-rst reload", e);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
